tmu_inject_mux: RTL and testbench
=================================

// Module: tmu_inject_mux
// PURPOSE
//  Parametrised multi-channel test/override mux between ADC front-end and DSP cores (CORDIC, PID).
//  Each channel independently passes live ADC data, injects a static value, generates a ramp or freezes a sample.
//  Injection can be time-limited to a sample count, after which the channel reverts to live ADC data.
//  Outputs are registered and accompanied by a sample-valid strobe for downstream cores.
// PARAMETERS
//  N_CH       4   number of channels (1..16)
//  DW         12  sample width, unsigned
//  LW         16  injection length counter width
//  RAMP_STEP  1   ramp increment per sample (DW bits, unsigned)
//  CHW        $clog2(N_CH) (min 1)  channel index width, derived, not overridable
// PORTS
//  clk        in   1        clock
//  rstn       in   1        asynchronous reset, active-low
//  adc_data   in   N_CH*DW  live samples, ch k at [k*DW +: DW]
//  adc_valid  in   1        common sample strobe, 1-cycle pulse
//  cfg_we     in   1        config write strobe
//  cfg_ch     in   CHW      target channel
//  cfg_mode   in   2        0 PASS, 1 INJECT, 2 RAMP, 3 HOLD
//  cfg_value  in   DW       inject value / ramp start value
//  cfg_len    in   LW       samples to stay in mode; 0 = unlimited
//  mux_data   out  N_CH*DW  registered channel outputs
//  mux_valid  out  1        1-cycle pulse, mux_data updated
//  ch_active  out  N_CH     channel state != PASS
//  inj_done   out  N_CH     1-cycle pulse when timed injection expires
// BEHAVIOUR
//  Reset: all channels PASS, mux_data=0, mux_valid=0, ch_active=0, inj_done=0, counters/held values 0.
//  Latency: mux_valid = adc_valid delayed 1 cycle; mux_data updated in the same cycle as mux_valid, else holds.
//  Per-channel FSM states PASS/INJECT/RAMP/HOLD; one cfg write per cycle, accepted unconditionally.
//  Write cfg_we with cfg_ch<N_CH: state<=cfg_mode, value<=cfg_value, remaining<=cfg_len, HOLD armed; effective next cycle.
//  cfg_ch>=N_CH: write ignored, no state change.
//  Write during active mode restarts channel with new settings; no inj_done pulse for aborted injection.
//  Write coincident with adc_valid: that sample uses pre-write state; new settings apply from next sample.
//  On each adc_valid, per channel output:
//   PASS:   adc_data[ch].
//   INJECT: value.
//   RAMP:   value, then value<=value+RAMP_STEP, wraps mod 2^DW (0xFFF+1 -> 0x000 at DW=12).
//   HOLD:   first sample after entry latched into value and output; later samples output latched value.
//  Length: when cfg_len!=0, each sample in non-PASS mode decrements remaining; sample that reaches 0 is
//   still output in the mode, state->PASS, inj_done pulses with that sample's mux_valid.
//  cfg_len ignored for PASS; ch_active = (state != PASS), registered, reflects state after writes/expiry.
//  Channels fully independent; simultaneous expiry on several channels pulses all corresponding inj_done bits.
//  rstn assertion mid-injection aborts immediately to reset state; no inj_done.
// TESTING
//  Reset then adc_valid with ch0=0x123 -> next cycle mux_valid=1, mux_data ch0=0x123, ch_active=0.
//  cfg ch1 INJECT value=0xABC len=3, 4 samples of 0x555 -> ch1 out ABC,ABC,ABC,555; inj_done[1] with 3rd sample.
//  cfg ch2 RAMP start=0xFFE len=0, 4 samples -> ch2 out FFE,FFF,000,001; ch_active[2] stays 1.
//  cfg ch3 HOLD, samples 0x010,0x020,0x030 -> ch3 out 010,010,010; cfg ch3 PASS -> next sample live, no inj_done.
//  cfg write ch0 INJECT 0x7 same cycle as adc_valid(ch0=0x100) -> that output 0x100, next sample 0x007.
//  rstn pulse during ch1 INJECT len=10 -> all outputs 0, ch_active=0, no inj_done; cfg_ch=N_CH write -> no effect.

Source files
------------

// File: rtl/tmu_inject_mux.sv
// Multi-channel test/override mux between the ADC front-end and the DSP cores.
// Each channel passes live data, injects a constant, ramps, or freezes a sample, optionally for a bounded sample count.
module tmu_inject_mux #(
  parameter int          N_CH      = 4,
  parameter int          DW        = 12,
  parameter int          LW        = 16,
  parameter int unsigned RAMP_STEP = 1,
  localparam int         CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_CH*DW-1:0]   adc_data,
  input  logic                 adc_valid,
  input  logic                 cfg_we,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [DW-1:0]        cfg_value,
  input  logic [LW-1:0]        cfg_len,
  output logic [N_CH*DW-1:0]   mux_data,
  output logic                 mux_valid,
  output logic [N_CH-1:0]      ch_active,
  output logic [N_CH-1:0]      inj_done
);

  typedef enum logic [1:0] {
    ST_PASS   = 2'd0,
    ST_INJECT = 2'd1,
    ST_RAMP   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [DW-1:0]   value_q [N_CH];
  logic [DW-1:0]   value_d [N_CH];
  logic [LW-1:0]   rem_q   [N_CH];
  logic [LW-1:0]   rem_d   [N_CH];
  logic            armed_q [N_CH];
  logic            armed_d [N_CH];

  logic [N_CH*DW-1:0] data_d;
  logic [N_CH-1:0]    done_d;
  logic [N_CH-1:0]    cfg_hit;

  // An out-of-range cfg_ch matches no channel, so the write simply falls away.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cfg_hit[k] = cfg_we && (32'(cfg_ch) == k);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    logic [DW-1:0] smp;
    data_d = mux_data;
    done_d = '0;
    smp    = '0;
    for (int k = 0; k < N_CH; k++) begin
      state_d[k] = state_q[k];
      value_d[k] = value_q[k];
      rem_d[k]   = rem_q[k];
      armed_d[k] = armed_q[k];
      smp        = adc_data[k*DW +: DW];

      if (adc_valid) begin
        unique case (state_q[k])
          ST_PASS:   data_d[k*DW +: DW] = smp;
          ST_INJECT: data_d[k*DW +: DW] = value_q[k];
          ST_RAMP: begin
            data_d[k*DW +: DW] = value_q[k];
            value_d[k]         = value_q[k] + DW'(RAMP_STEP);
          end
          ST_HOLD: begin
            if (armed_q[k]) begin
              data_d[k*DW +: DW] = smp;
              value_d[k]         = smp;
              armed_d[k]         = 1'b0;
            end else begin
              data_d[k*DW +: DW] = value_q[k];
            end
          end
          default: data_d[k*DW +: DW] = smp;
        endcase

        // A zero remaining count in a non-PASS state means the mode is unlimited.
        if (state_q[k] != ST_PASS && rem_q[k] != '0) begin
          rem_d[k] = rem_q[k] - LW'(1);
          if (rem_q[k] == LW'(1)) begin
            state_d[k] = ST_PASS;
            done_d[k]  = 1'b1;
          end
        end
      end

      // A config write overrides the sample's state update and cancels any expiry pulse.
      if (cfg_hit[k]) begin
        state_d[k] = state_e'(cfg_mode);
        value_d[k] = cfg_value;
        rem_d[k]   = (state_e'(cfg_mode) == ST_PASS) ? '0 : cfg_len;
        armed_d[k] = 1'b1;
        done_d[k]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mux_data  <= '0;
      mux_valid <= 1'b0;
      inj_done  <= '0;
      // NOTE: the per-channel arrays are a handful of flops, not a RAM, so resetting them is intended.
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= ST_PASS;
        value_q[k] <= '0;
        rem_q[k]   <= '0;
        armed_q[k] <= 1'b0;
      end
    end else begin
      mux_data  <= data_d;
      mux_valid <= adc_valid;
      inj_done  <= done_d;
      for (int k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        value_q[k] <= value_d[k];
        rem_q[k]   <= rem_d[k];
        armed_q[k] <= armed_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_active[k] = (state_q[k] != ST_PASS);
    end
  end

endmodule

// File: tb/tb_tmu_inject_mux.sv
// Bench for tmu_inject_mux: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a sample-level behavioural model.
module tb_tmu_inject_mux;

  localparam int N    = 5;
  localparam int DW   = 12;
  localparam int LW   = 16;
  localparam int STEP = 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic [N*DW-1:0]   adc_data;
  logic              adc_valid;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [1:0]        cfg_mode;
  logic [DW-1:0]     cfg_value;
  logic [LW-1:0]     cfg_len;
  logic [N*DW-1:0]   mux_data;
  logic              mux_valid;
  logic [N-1:0]      ch_active;
  logic [N-1:0]      inj_done;

  tmu_inject_mux #(.N_CH(N), .DW(DW), .LW(LW), .RAMP_STEP(STEP)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_value (cfg_value),
    .cfg_len   (cfg_len),
    .mux_data  (mux_data),
    .mux_valid (mux_valid),
    .ch_active (ch_active),
    .inj_done  (inj_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: each channel is a mode number, a value, a remaining-sample count and a "first HOLD sample" flag.
  int          m_mode  [N];
  int          m_val   [N];
  int          m_rem   [N];
  bit          m_armed [N];
  int          exp_data[N];
  bit          exp_valid;
  bit [N-1:0]  exp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_mode[c] = 0; m_val[c] = 0; m_rem[c] = 0; m_armed[c] = 0; exp_data[c] = 0;
    end
    exp_valid = 0;
    exp_done  = '0;
  endtask

  // Called right after a rising edge, while the inputs the DUT just sampled are still applied.
  task automatic model_update();
    exp_valid = adc_valid;
    exp_done  = '0;
    if (adc_valid) begin
      for (int c = 0; c < N; c++) begin
        int live;
        live = int'(adc_data[c*DW +: DW]);
        case (m_mode[c])
          0: exp_data[c] = live;
          1: exp_data[c] = m_val[c];
          2: begin exp_data[c] = m_val[c]; m_val[c] = (m_val[c] + STEP) % 4096; end
          default: begin
            if (m_armed[c]) begin m_val[c] = live; m_armed[c] = 0; end
            exp_data[c] = m_val[c];
          end
        endcase
        if (m_mode[c] != 0 && m_rem[c] > 0) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin m_mode[c] = 0; exp_done[c] = 1'b1; end
        end
      end
    end
    if (cfg_we && cfg_ch < N) begin
      m_mode[cfg_ch]  = int'(cfg_mode);
      m_val[cfg_ch]   = int'(cfg_value);
      m_rem[cfg_ch]   = (cfg_mode == 2'd0) ? 0 : int'(cfg_len);
      m_armed[cfg_ch] = 1'b1;
      exp_done[cfg_ch] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mux_valid", {31'd0, mux_valid}, {31'd0, exp_valid});
      check("inj_done", {27'd0, inj_done}, {27'd0, exp_done});
      for (int c = 0; c < N; c++) begin
        check($sformatf("mux_data[%0d]", c), {20'd0, mux_data[c*DW +: DW]}, exp_data[c]);
        check($sformatf("ch_active[%0d]", c), {31'd0, ch_active[c]}, {31'd0, m_mode[c] != 0});
      end
    end
  end

  function automatic logic [DW-1:0] ch_out(input int c);
    return mux_data[c*DW +: DW];
  endfunction

  function automatic logic [N*DW-1:0] rand_adc();
    logic [N*DW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'($urandom_range(0, 4095));
    return v;
  endfunction

  function automatic logic [N*DW-1:0] put(input logic [N*DW-1:0] base, input int c, input logic [DW-1:0] s);
    logic [N*DW-1:0] v;
    v = base;
    v[c*DW +: DW] = s;
    return v;
  endfunction

  task automatic step(input logic av, input logic [N*DW-1:0] adc, input logic we, input logic [2:0] ch,
                      input logic [1:0] mode, input logic [DW-1:0] val, input logic [LW-1:0] len);
    adc_valid = av; adc_data = adc;
    cfg_we = we; cfg_ch = ch; cfg_mode = mode; cfg_value = val; cfg_len = len;
    @(posedge clk);
    model_update();
    #1;
    adc_valid = 1'b0;
    cfg_we    = 1'b0;
  endtask

  task automatic sample(input logic [N*DW-1:0] adc);
    step(1'b1, adc, 1'b0, 3'd0, 2'd0, '0, '0);
  endtask

  task automatic cfg(input logic [2:0] ch, input logic [1:0] mode, input logic [DW-1:0] val, input logic [LW-1:0] len);
    step(1'b0, rand_adc(), 1'b1, ch, mode, val, len);
  endtask

  logic [DW-1:0] seq [4];

  initial begin
    adc_valid = 0; adc_data = '0; cfg_we = 0; cfg_ch = '0; cfg_mode = '0; cfg_value = '0; cfg_len = '0;
    model_reset();
    #2 rstn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst mux_data", {20'd0, ch_out(0)}, 32'h0);
    check("rst mux_valid", {31'd0, mux_valid}, 32'd0);
    check("rst ch_active", {27'd0, ch_active}, 32'd0);
    rstn = 1'b1;

    // Live pass-through after reset.
    sample(put(rand_adc(), 0, 12'h123));
    check("pass ch0", {20'd0, ch_out(0)}, 32'h123);
    check("pass valid", {31'd0, mux_valid}, 32'd1);
    check("pass active", {27'd0, ch_active}, 32'd0);

    // Timed injection of 3 samples on ch1.
    cfg(3'd1, 2'd1, 12'hABC, 16'd3);
    for (int i = 0; i < 4; i++) begin
      sample({N{12'h555}});
      seq[i] = ch_out(1);
      if (i == 2) check("inject done pulse", {27'd0, inj_done}, 32'b00010);
    end
    check("inject s0", {20'd0, seq[0]}, 32'hABC);
    check("inject s2", {20'd0, seq[2]}, 32'hABC);
    check("inject s3", {20'd0, seq[3]}, 32'h555);
    check("inject active off", {31'd0, ch_active[1]}, 32'd0);

    // Unlimited ramp across the wrap point.
    cfg(3'd2, 2'd2, 12'hFFE, 16'd0);
    for (int i = 0; i < 4; i++) begin sample(rand_adc()); seq[i] = ch_out(2); end
    check("ramp s0", {20'd0, seq[0]}, 32'hFFE);
    check("ramp s1", {20'd0, seq[1]}, 32'hFFF);
    check("ramp s2", {20'd0, seq[2]}, 32'h000);
    check("ramp s3", {20'd0, seq[3]}, 32'h001);
    check("ramp active", {31'd0, ch_active[2]}, 32'd1);

    // Freeze on ch3, then release to live data without a done pulse.
    cfg(3'd3, 2'd3, 12'h000, 16'd0);
    for (int i = 0; i < 3; i++) begin sample(put(rand_adc(), 3, DW'((i + 1) * 16))); seq[i] = ch_out(3); end
    check("hold s0", {20'd0, seq[0]}, 32'h010);
    check("hold s2", {20'd0, seq[2]}, 32'h010);
    cfg(3'd3, 2'd0, 12'h000, 16'd5);
    sample(put(rand_adc(), 3, 12'h040));
    check("hold release", {20'd0, ch_out(3)}, 32'h040);
    check("hold no done", {31'd0, inj_done[3]}, 32'd0);

    // Write coincident with a sample: that sample still sees the old mode.
    step(1'b1, put(rand_adc(), 0, 12'h100), 1'b1, 3'd0, 2'd1, 12'h007, 16'd0);
    check("coincident old", {20'd0, ch_out(0)}, 32'h100);
    sample(rand_adc());
    check("coincident new", {20'd0, ch_out(0)}, 32'h007);

    // Two channels expiring on the same sample.
    cfg(3'd0, 2'd1, 12'h111, 16'd2);
    cfg(3'd4, 2'd2, 12'h200, 16'd2);
    sample(rand_adc());
    sample(rand_adc());
    check("dual expiry", {27'd0, inj_done}, 32'b10001);

    // Reset in the middle of a long injection.
    cfg(3'd1, 2'd1, 12'h3C3, 16'd10);
    sample(rand_adc());
    sample(rand_adc());
    rstn = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("midrst data", {20'd0, ch_out(1)}, 32'h0);
    check("midrst active", {27'd0, ch_active}, 32'd0);
    check("midrst done", {27'd0, inj_done}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // A write to a non-existent channel changes nothing.
    cfg(3'(N), 2'd1, 12'hEEE, 16'd0);
    check("bad ch active", {27'd0, ch_active}, 32'd0);
    sample(put(rand_adc(), 4, 12'h0F0));
    check("bad ch live", {20'd0, ch_out(4)}, 32'h0F0);

    // Random traffic, checked by the compare process every cycle.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), rand_adc(), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), DW'($urandom_range(0, 4095)), LW'($urandom_range(0, 4)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
